bpc_decomp_arbiter: RTL and testbench



---
 rtl/bpc_decomp_arbiter_if.sv | 45 ++++
 rtl/bpc_decomp_arbiter.sv | 163 ++++++++++++++++
 tb/tb_bpc_decomp_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bpc_decomp_arbiter_if.sv
// rtl/bpc_decomp_arbiter_if.sv - requester, decoder and output stream bundle for the decoder arbiter
interface bpc_decomp_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 64
);
    logic [NUM_REQ*DATA_W-1:0] req_data_i;
    logic [NUM_REQ-1:0]        req_valid_i;
    logic [NUM_REQ-1:0]        req_sop_i;
    logic [NUM_REQ-1:0]        req_eop_i;
    logic [NUM_REQ-1:0]        req_ready_o;
    logic [DATA_W-1:0]         dec_data_o;
    logic                      dec_valid_o;
    logic                      dec_sop_o;
    logic                      dec_eop_o;
    logic                      dec_ready_i;
    logic [DATA_W-1:0]         dec_data_i;
    logic                      dec_valid_i;
    logic                      dec_sop_i;
    logic                      dec_eop_i;
    logic                      dec_ready_o;
    logic [DATA_W-1:0]         out_data_o;
    logic [NUM_REQ-1:0]        out_valid_o;
    logic                      out_sop_o;
    logic                      out_eop_o;
    logic [NUM_REQ-1:0]        out_ready_i;
    logic                      err_o;

    modport slave (
        input  req_data_i, req_valid_i, req_sop_i, req_eop_i,
        input  dec_ready_i, dec_data_i, dec_valid_i, dec_sop_i, dec_eop_i,
        input  out_ready_i,
        output req_ready_o, dec_data_o, dec_valid_o, dec_sop_o, dec_eop_o,
        output dec_ready_o, out_data_o, out_valid_o, out_sop_o, out_eop_o,
        output err_o
    );

    modport master (
        output req_data_i, req_valid_i, req_sop_i, req_eop_i,
        output dec_ready_i, dec_data_i, dec_valid_i, dec_sop_i, dec_eop_i,
        output out_ready_i,
        input  req_ready_o, dec_data_o, dec_valid_o, dec_sop_o, dec_eop_o,
        input  dec_ready_o, out_data_o, out_valid_o, out_sop_o, out_eop_o,
        input  err_o
    );
endinterface

// File: rtl/bpc_decomp_arbiter.sv
// rtl/bpc_decomp_arbiter.sv - packet-granular round-robin share of one bit-plane decoder
module bpc_decomp_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int IDX_W     = 2,
    parameter int DATA_W    = 64,
    parameter int TAG_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    bpc_decomp_arbiter_if.slave   bus
);
    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {IDLE, LOCK} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   tag_mem_q [TAG_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               err_q, err_d;

    logic               fifo_full, fifo_empty, push, pop, in_err, out_err;
    logic [IDX_W-1:0]   head, cand, sop_idx, valid_idx;
    logic               sop_found, valid_found;
    logic [NUM_REQ-1:0] req_ready, out_valid;
    logic [DATA_W-1:0]  dec_data;
    logic               dec_valid, dec_sop, dec_eop, dec_ready;

    function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base, input int offs);
        int sum;
        sum = int'(base) + offs;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return IDX_W'(sum);
    endfunction

    assign fifo_full  = (count_q == CNT_W'(TAG_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign head       = tag_mem_q[rd_ptr_q];

    // Input side: pick a packet owner in IDLE, then pass its beats straight through in LOCK.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        push        = 1'b0;
        in_err      = 1'b0;
        req_ready   = '0;
        dec_data    = '0;
        dec_valid   = 1'b0;
        dec_sop     = 1'b0;
        dec_eop     = 1'b0;
        cand        = '0;
        sop_found   = 1'b0;
        valid_found = 1'b0;
        sop_idx     = '0;
        valid_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = rr_index(rr_ptr_q, i);
            if (!valid_found && bus.req_valid_i[cand]) begin
                valid_found = 1'b1;
                valid_idx   = cand;
            end
            if (!sop_found && bus.req_valid_i[cand] && bus.req_sop_i[cand]) begin
                sop_found = 1'b1;
                sop_idx   = cand;
            end
        end
        case (state_q)
            IDLE: begin
                if (sop_found && !fifo_full) begin
                    grant_d = sop_idx;
                    state_d = LOCK;
                end else if (valid_found && !bus.req_sop_i[valid_idx]) begin
                    // A stray mid-packet beat with no owner is flushed so it cannot wedge the port.
                    req_ready[valid_idx] = 1'b1;
                    in_err               = 1'b1;
                end
            end
            LOCK: begin
                dec_data           = bus.req_data_i[int'(grant_q)*DATA_W +: DATA_W];
                dec_valid          = bus.req_valid_i[grant_q];
                dec_sop            = bus.req_sop_i[grant_q];
                dec_eop            = bus.req_eop_i[grant_q];
                req_ready[grant_q] = bus.dec_ready_i;
                if (dec_valid && bus.dec_ready_i) begin
                    if (dec_sop) begin
                        if (fifo_full) in_err = 1'b1;
                        else           push   = 1'b1;
                    end
                    if (dec_eop) begin
                        state_d  = IDLE;
                        rr_ptr_d = rr_index(grant_q, 1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output side: decoded packets return in issue order, so the FIFO head names the owner.
    always_comb begin
        out_valid = '0;
        dec_ready = 1'b1;
        pop       = 1'b0;
        out_err   = 1'b0;
        if (fifo_empty) begin
            out_err = bus.dec_valid_i;
        end else begin
            out_valid[head] = bus.dec_valid_i;
            dec_ready       = bus.out_ready_i[head];
            pop             = bus.dec_valid_i && bus.out_ready_i[head] && bus.dec_eop_i;
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
        err_d = err_q | in_err | out_err;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) tag_mem_q[wr_ptr_q] <= grant_q;
    end

    assign bus.req_ready_o = req_ready;
    assign bus.dec_data_o  = dec_data;
    assign bus.dec_valid_o = dec_valid;
    assign bus.dec_sop_o   = dec_sop;
    assign bus.dec_eop_o   = dec_eop;
    assign bus.dec_ready_o = dec_ready;
    assign bus.out_data_o  = bus.dec_data_i;
    assign bus.out_valid_o = out_valid;
    assign bus.out_sop_o   = bus.dec_sop_i;
    assign bus.out_eop_o   = bus.dec_eop_i;
    assign bus.err_o       = err_q;
endmodule

// File: tb/tb_bpc_decomp_arbiter.sv
// tb/tb_bpc_decomp_arbiter.sv - scoreboard bench: random requesters, decoder model, round-robin reference
module tb_bpc_decomp_arbiter;
    localparam int NUM_REQ   = 4;
    localparam int IDX_W     = 2;
    localparam int DATA_W    = 64;
    localparam int TAG_DEPTH = 4;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              sop;
        logic              eop;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bpc_decomp_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

    bpc_decomp_arbiter #(
        .NUM_REQ(NUM_REQ), .IDX_W(IDX_W), .DATA_W(DATA_W), .TAG_DEPTH(TAG_DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    beat_t cq[NUM_REQ][$];
    beat_t exp_dec[NUM_REQ][$];
    beat_t exp_out[NUM_REQ][$];
    beat_t dq[$];
    int    pkts_left[NUM_REQ];
    int    p_start, p_dready, p_oready, p_dvalid;
    bit    t1_pattern, force_dec, dec_forced;
    int    din_beats;

    int    tagq[$];
    int    grant_log[$];
    int    m_rr, m_owner, m_win, m_first, m_head;
    bit    m_lock, m_err, m_push, m_pop, m_close, m_new_err, m_was_lock;
    logic [NUM_REQ-1:0] m_rdy, m_ov;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int start);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (v[(start + i) % NUM_REQ]) return (start + i) % NUM_REQ;
        end
        return -1;
    endfunction

    // Reference: round-robin owner per packet, in-order tag list, decoded beats expected per requester.
    always @(negedge clk) begin
        if (rst) begin
            m_lock = 0;
            m_rr   = 0;
            m_err  = 0;
            tagq.delete();
            for (int r = 0; r < NUM_REQ; r++) begin
                exp_dec[r].delete();
                exp_out[r].delete();
            end
        end else begin
            chk("err_o", 128'(bus.err_o), 128'(m_err));
            m_push = 0; m_pop = 0; m_close = 0; m_new_err = 0; m_win = -1;
            m_was_lock = m_lock;
            m_rdy = '0;
            if (!m_lock) begin
                chk("dec_valid_idle", 128'(bus.dec_valid_o), 128'(0));
                if (tagq.size() < TAG_DEPTH)
                    m_win = rr_pick(bus.req_valid_i & bus.req_sop_i, m_rr);
                if (m_win < 0) begin
                    m_first = rr_pick(bus.req_valid_i, m_rr);
                    if (m_first >= 0 && !bus.req_sop_i[m_first]) begin
                        m_rdy[m_first] = 1'b1;
                        m_new_err      = 1;
                    end
                end
                chk("req_ready_idle", 128'(bus.req_ready_o), 128'(m_rdy));
            end else begin
                chk("dec_valid_lock", 128'(bus.dec_valid_o), 128'(bus.req_valid_i[m_owner]));
                m_rdy[m_owner] = bus.dec_ready_i;
                chk("req_ready_lock", 128'(bus.req_ready_o), 128'(m_rdy));
                if (bus.dec_valid_o) begin
                    if (exp_dec[m_owner].size() == 0) begin
                        chk("dec_extra_beat", 128'(exp_dec[m_owner].size()), 128'(1));
                    end else begin
                        chk("dec_beat", 128'({bus.dec_data_o, bus.dec_sop_o, bus.dec_eop_o}),
                            128'(exp_dec[m_owner][0]));
                        if (bus.dec_ready_i) begin
                            m_push  = bus.dec_sop_o;
                            m_close = bus.dec_eop_o;
                            exp_dec[m_owner].delete(0);
                        end
                    end
                end
            end
            if (tagq.size() == 0) begin
                chk("dec_ready_empty", 128'(bus.dec_ready_o), 128'(1));
                chk("out_valid_empty", 128'(bus.out_valid_o), 128'(0));
                if (bus.dec_valid_i) m_new_err = 1;
            end else begin
                m_head = tagq[0];
                m_ov   = '0;
                m_ov[m_head] = bus.dec_valid_i;
                chk("out_valid", 128'(bus.out_valid_o), 128'(m_ov));
                chk("dec_ready_out", 128'(bus.dec_ready_o), 128'(bus.out_ready_i[m_head]));
                if (bus.dec_valid_i && bus.out_ready_i[m_head]) begin
                    if (exp_out[m_head].size() == 0) begin
                        chk("out_extra_beat", 128'(exp_out[m_head].size()), 128'(1));
                    end else begin
                        chk("out_beat", 128'({bus.out_data_o, bus.out_sop_o, bus.out_eop_o}),
                            128'(exp_out[m_head][0]));
                        exp_out[m_head].delete(0);
                    end
                    m_pop = bus.dec_eop_i;
                end
            end
            if (m_pop) tagq.delete(0);
            if (m_push) tagq.push_back(m_owner);
            if (m_close) begin
                m_lock = 0;
                m_rr   = (m_owner + 1) % NUM_REQ;
            end
            if (!m_was_lock && m_win >= 0) begin
                m_lock  = 1;
                m_owner = m_win;
                grant_log.push_back(m_win);
            end
            if (m_new_err) m_err = 1;
        end
    end

    task automatic new_packet(input int r);
        int    len;
        beat_t b, ob;
        len = t1_pattern ? 8 : int'($urandom_range(1, 6));
        for (int i = 0; i < len; i++) begin
            b.data = t1_pattern ? DATA_W'({8'(i + 1), 8'(i + 1)}) : {$urandom, $urandom};
            b.sop  = (i == 0);
            b.eop  = (i == len - 1);
            ob      = b;
            ob.data = ~b.data;
            cq[r].push_back(b);
            exp_dec[r].push_back(b);
            exp_out[r].push_back(ob);
        end
    endtask

    task automatic step();
        logic [NUM_REQ-1:0] acc_r;
        logic               dout_acc;
        beat_t              b;
        @(negedge clk);
        acc_r    = bus.req_valid_i & bus.req_ready_o;
        dout_acc = bus.dec_valid_i & bus.dec_ready_o;
        if (bus.dec_valid_o && bus.dec_ready_i) begin
            b.data = bus.dec_data_o;
            b.sop  = bus.dec_sop_o;
            b.eop  = bus.dec_eop_o;
            dq.push_back(b);
            din_beats++;
        end
        @(posedge clk);
        #1;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (acc_r[r] && cq[r].size() > 0) cq[r].delete(0);
            if (cq[r].size() == 0 && pkts_left[r] > 0 && int'($urandom_range(1, 100)) <= p_start) begin
                new_packet(r);
                pkts_left[r]--;
            end
            if (cq[r].size() > 0) begin
                bus.req_valid_i[r] = 1'b1;
                bus.req_sop_i[r]   = cq[r][0].sop;
                bus.req_eop_i[r]   = cq[r][0].eop;
                bus.req_data_i[r*DATA_W +: DATA_W] = cq[r][0].data;
            end else begin
                bus.req_valid_i[r] = 1'b0;
                bus.req_sop_i[r]   = 1'b0;
                bus.req_eop_i[r]   = 1'b0;
                bus.req_data_i[r*DATA_W +: DATA_W] = '0;
            end
            bus.out_ready_i[r] = (int'($urandom_range(1, 100)) <= p_oready);
        end
        bus.dec_ready_i = (int'($urandom_range(1, 100)) <= p_dready);
        if (dout_acc && !dec_forced && dq.size() > 0) dq.delete(0);
        if (force_dec) begin
            bus.dec_valid_i = 1'b1;
            bus.dec_data_i  = 64'hdead_beef_0000_0001;
            bus.dec_sop_i   = 1'b1;
            bus.dec_eop_i   = 1'b1;
            dec_forced      = 1;
        end else if (!(bus.dec_valid_i && !dout_acc && !dec_forced)) begin
            dec_forced      = 0;
            bus.dec_valid_i = (dq.size() > 0) && (int'($urandom_range(1, 100)) <= p_dvalid);
            bus.dec_data_i  = (dq.size() > 0) ? ~dq[0].data : '0;
            bus.dec_sop_i   = (dq.size() > 0) ? dq[0].sop : 1'b0;
            bus.dec_eop_i   = (dq.size() > 0) ? dq[0].eop : 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int r = 0; r < NUM_REQ; r++) begin
            cq[r].delete();
            pkts_left[r] = 0;
        end
        dq.delete();
        force_dec = 0; dec_forced = 0;
        bus.req_data_i = '0; bus.req_valid_i = '0; bus.req_sop_i = '0; bus.req_eop_i = '0;
        bus.dec_data_i = '0; bus.dec_valid_i = 1'b0; bus.dec_sop_i = 1'b0; bus.dec_eop_i = 1'b0;
        bus.dec_ready_i = 1'b0; bus.out_ready_i = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        grant_log.delete();
    endtask

    function automatic bit busy();
        busy = dq.size() != 0 || tagq.size() != 0 || m_lock || bus.dec_valid_i;
        for (int r = 0; r < NUM_REQ; r++)
            if (cq[r].size() != 0 || pkts_left[r] != 0 || exp_dec[r].size() != 0 || exp_out[r].size() != 0)
                busy = 1;
    endfunction

    task automatic run_until_idle(input string name, input int max_cycles);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (busy() && n < max_cycles);
        chk(name, 128'(busy()), 128'(0));
    endtask

    function automatic int log_word();
        log_word = 0;
        foreach (grant_log[i]) log_word = log_word * 16 + grant_log[i];
    endfunction

    initial begin
        p_start = 100; p_dready = 100; p_oready = 100; p_dvalid = 100;
        t1_pattern = 0;
        do_reset();
        chk("reset_outputs", 128'({bus.req_ready_o, bus.dec_valid_o, bus.out_valid_o, bus.err_o}), 128'(0));

        t1_pattern = 1; din_beats = 0; pkts_left[1] = 1;
        run_until_idle("t1_drain", 200);
        chk("t1_dec_beats", 128'(din_beats), 128'(8));
        t1_pattern = 0;

        do_reset();
        pkts_left[0] = 2; pkts_left[2] = 2;
        run_until_idle("t2_drain", 400);
        chk("t2_grant_order", 128'(log_word()), 128'(16'h0202));

        t1_pattern = 1; din_beats = 0; p_dready = 40; pkts_left[1] = 1;
        run_until_idle("t3_drain", 400);
        chk("t3_dec_beats", 128'(din_beats), 128'(8));
        t1_pattern = 0; p_dready = 100;

        begin
            beat_t stray;
            stray.data = 64'h5a5a; stray.sop = 1'b0; stray.eop = 1'b1;
            cq[3].push_back(stray);
        end
        repeat (3) step();
        chk("t5_stray_dropped", 128'(cq[3].size()), 128'(0));
        chk("t5_stray_err", 128'(bus.err_o), 128'(1));

        do_reset();
        force_dec = 1;
        step();
        force_dec = 0;
        repeat (3) step();
        chk("t5_empty_err", 128'(bus.err_o), 128'(1));

        do_reset();
        t1_pattern = 1; din_beats = 0; pkts_left[1] = 1;
        for (int n = 0; n < 60 && din_beats < 4; n++) step();
        chk("t6_mid_packet", 128'(din_beats), 128'(4));
        do_reset();
        chk("t6_post_reset", 128'({bus.req_ready_o, bus.dec_valid_o, bus.out_valid_o, bus.err_o}), 128'(0));
        pkts_left[0] = 1; pkts_left[1] = 1; pkts_left[3] = 1;
        run_until_idle("t6_drain", 400);
        chk("t6_grant_order", 128'(log_word()), 128'(12'h013));
        t1_pattern = 0;

        p_start = 30; p_dready = 70; p_oready = 60; p_dvalid = 70;
        for (int r = 0; r < NUM_REQ; r++) pkts_left[r] = 15;
        run_until_idle("random_drain", 20000);

        p_start = 100; p_oready = 0; p_dready = 100; p_dvalid = 100;
        grant_log.delete();
        for (int r = 0; r < NUM_REQ; r++) pkts_left[r] = 2;
        repeat (80) step();
        chk("t4_grants_full", 128'(grant_log.size()), 128'(TAG_DEPTH));
        chk("t4_stalled", 128'({bus.dec_valid_o, bus.req_ready_o}), 128'(0));
        p_oready = 100;
        run_until_idle("t4_drain", 2000);
        chk("t4_all_grants", 128'(grant_log.size()), 128'(2 * NUM_REQ));
        chk("final_err", 128'(bus.err_o), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
